// File: rtl/mac_row_engine_pkg.sv
// Shared FSM state type and beat-count helpers for mac_row_engine.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Beat counter must be able to hold the value BEATS itself (rollover compare).
  function automatic int beat_cnt_w(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/mac_row_engine_if.sv
// Pixel/weight memory read bus: per-lane addresses out, per-lane data back one cycle later.
interface mac_row_engine_if #(
  parameter int LANES     = 2,
  parameter int PIXEL_W   = 8,
  parameter int WEIGHT_W  = 16,
  parameter int PIXEL_AW  = 10,
  parameter int WEIGHT_AW = 13
);
  logic [LANES*PIXEL_AW-1:0]  pixel_addr;
  logic [LANES*WEIGHT_AW-1:0] weight_addr;
  logic [LANES*PIXEL_W-1:0]   pixel_data;
  logic [LANES*WEIGHT_W-1:0]  weight_data;

  modport master (output pixel_addr, output weight_addr, input pixel_data, input weight_data);
  modport slave  (input pixel_addr, input weight_addr, output pixel_data, output weight_data);
endinterface

// File: rtl/mac_row_engine_flex_counter.sv
// Up-counter 0..rollover_val-1 with synchronous clear; flag marks the final count.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
)(
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  assign rollover_flag = (count_out == rollover_val - 1'b1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)            count_out <= '0;
    else if (clear)        count_out <= '0;
    else if (count_enable) count_out <= rollover_flag ? '0 : count_out + 1'b1;
  end

endmodule

// File: rtl/mac_row_engine.sv
// Row dot-product engine: LANES-wide pixel x weight MAC accumulated over one weight row.
// Build option MAC_ROW_SATURATE_EN clamps the accumulator at all-ones once it overflows.
module mac_row_engine
  import mac_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int PIXEL_W     = 8,
  parameter int WEIGHT_W    = 16,
  parameter int RES_W       = 16,
  parameter int VEC_LEN     = 784,
  parameter int NUM_ROWS    = 10,
  parameter int PIXEL_AW    = 10,
  parameter int WEIGHT_AW   = 13,
  parameter int PIXEL_BASE  = 0,
  parameter int WEIGHT_BASE = 0
)(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       row_select,
  mac_row_engine_if.master mem,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             overflow,
  output logic             row_err
);

  localparam int BEATS  = ceil_div(VEC_LEN, LANES);
  localparam int CNT_W  = beat_cnt_w(BEATS);
  localparam int PROD_W = PIXEL_W + WEIGHT_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES + 1);
  localparam int ADD_W  = ((SUM_W > RES_W) ? SUM_W : RES_W) + 1;

  state_t             state, state_nxt;
  logic               start_ok, start_bad, last_beat;
  logic [CNT_W-1:0]   beat;
  logic [3:0]         row_q;
  logic [LANES-1:0]   lane_mask, mask_p0;
  logic               vld_p0;
  logic [SUM_W-1:0]   beat_sum;
  logic [RES_W:0]     acc_p1, acc_nxt;
  int                 elem;

  // Accumulator MSB is the sticky overflow flag; low RES_W bits carry the running sum.
  function automatic logic [RES_W:0] acc_step(input logic [RES_W:0] acc, input logic [SUM_W-1:0] add);
    logic [ADD_W-1:0] sum;
    logic             ovf;
    sum = ADD_W'(acc[RES_W-1:0]) + ADD_W'(add);
    ovf = acc[RES_W] | (sum > ADD_W'({RES_W{1'b1}}));
`ifdef MAC_ROW_SATURATE_EN
    if (ovf) return {1'b1, {RES_W{1'b1}}};
`endif
    return {ovf, sum[RES_W-1:0]};
  endfunction

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (int'(row_select) < NUM_ROWS) begin
            start_ok  = 1'b1;
            state_nxt = ISSUE;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ISSUE:   state_nxt = abort ? IDLE : (last_beat ? DRAIN : ISSUE);
      DRAIN:   state_nxt = abort ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_beat_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (start_ok | abort),
    .count_enable  (state == ISSUE),
    .rollover_val  (CNT_W'(BEATS)),
    .count_out     (beat),
    .rollover_flag (last_beat)
  );

  // Stage p0 issue: addresses for the current beat; tail lanes repeat lane 0 and are masked.
  always_comb begin
    mem.pixel_addr  = '0;
    mem.weight_addr = '0;
    lane_mask       = '0;
    elem            = 0;
    for (int i = 0; i < LANES; i++) begin
      elem = int'(beat) * LANES + i;
      if (elem < VEC_LEN) lane_mask[i] = 1'b1;
      else                elem = int'(beat) * LANES;
      mem.pixel_addr[i*PIXEL_AW +: PIXEL_AW]    = PIXEL_AW'(PIXEL_BASE + elem);
      mem.weight_addr[i*WEIGHT_AW +: WEIGHT_AW] = WEIGHT_AW'(WEIGHT_BASE + int'(row_q) * VEC_LEN + elem);
    end
  end

  // Stage p1: memory data of the previous beat arrives; multiply, mask and reduce.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask_p0[i])
        beat_sum = beat_sum + SUM_W'(PROD_W'(mem.pixel_data[i*PIXEL_W +: PIXEL_W]) *
                                     PROD_W'(mem.weight_data[i*WEIGHT_W +: WEIGHT_W]));
    end
  end

  assign acc_nxt = acc_step(acc_p1, beat_sum);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      row_q    <= '0;
      vld_p0   <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      row_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      row_err <= start_bad;
      vld_p0  <= (state == ISSUE) && !abort;
      if (start_ok) row_q <= row_select;
      if (state == DRAIN && !abort) begin
        result   <= acc_nxt[RES_W-1:0];
        overflow <= acc_nxt[RES_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    mask_p0 <= lane_mask;
    if (start_ok)    acc_p1 <= '0;
    else if (vld_p0) acc_p1 <= acc_nxt;
  end

endmodule

// File: tb/tb_mac_row_engine.sv
// Scoreboard bench for mac_row_engine: default-size DUT with a sum-of-products reference, plus a 4-lane masking instance.
module tb_mac_row_engine;

  localparam int VEC = 784;
  localparam int LAT = 393;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic        start, abort;
  logic [3:0]  row_select;
  logic        busy, done, overflow, row_err;
  logic [15:0] result;

  logic        s_start, s_abort;
  logic [3:0]  s_row;
  logic        s_busy, s_done, s_overflow, s_row_err;
  logic [15:0] s_result;

  mac_row_engine_if #(.LANES(2)) bus ();
  mac_row_engine_if #(.LANES(4)) sbus ();

  mac_row_engine u_dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .row_select(row_select),
    .mem(bus), .busy(busy), .done(done), .result(result), .overflow(overflow), .row_err(row_err)
  );

  mac_row_engine #(.LANES(4), .VEC_LEN(10)) u_small (
    .clk(clk), .n_rst(n_rst), .start(s_start), .abort(s_abort), .row_select(s_row),
    .mem(sbus), .busy(s_busy), .done(s_done), .result(s_result), .overflow(s_overflow), .row_err(s_row_err)
  );

  typedef struct { logic [15:0] res; logic ovf; int scyc; } exp_t;
  exp_t sbq[$];
  exp_t got;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wmin, wmax, ss, n;
  logic [15:0] prev_res;
  logic        prev_ovf;

  logic [7:0]  pix_mem [1024];
  logic [15:0] wgt_mem [8192];
  logic [7:0]  sm_pix  [1024];
  logic [15:0] sm_wgt  [8192];

  always @(posedge clk) cyc <= cyc + 1;

  // Memories with one-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bus.pixel_data[i*8 +: 8]    <= pix_mem[bus.pixel_addr[i*10 +: 10]];
      bus.weight_data[i*16 +: 16] <= wgt_mem[bus.weight_addr[i*13 +: 13]];
    end
    for (int i = 0; i < 4; i++) begin
      sbus.pixel_data[i*8 +: 8]    <= sm_pix[sbus.pixel_addr[i*10 +: 10]];
      sbus.weight_data[i*16 +: 16] <= sm_wgt[sbus.weight_addr[i*13 +: 13]];
    end
  end

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (n_rst && done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done result=%0d required=no done", result);
      end else begin
        got = sbq.pop_front();
        chk("sb_result", longint'(result), longint'(got.res));
        chk("sb_overflow", longint'(overflow), longint'(got.ovf));
        chk("sb_latency", longint'(cyc - got.scyc), LAT);
      end
    end
  end

  // Reference: plain dot product over the whole row, then wrap or clamp to 16 bits.
  task automatic push_exp(input int row);
    longint s;
    exp_t   e;
    s = 0;
    for (int k = 0; k < VEC; k++) s += longint'(pix_mem[k]) * longint'(wgt_mem[row*VEC + k]);
    e.ovf = (s > 65535);
`ifdef MAC_ROW_SATURATE_EN
    e.res = e.ovf ? 16'hFFFF : 16'(s);
`else
    e.res = 16'(s);
`endif
    e.scyc = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < 1024; k++)
      pix_mem[k] = (mode == 2) ? 8'd1 : (mode == 3) ? 8'd255 :
                   (mode == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
    for (int k = 0; k < 8192; k++)
      wgt_mem[k] = (mode == 2) ? 16'd2 : (mode == 3) ? 16'd255 :
                   (mode == 0) ? 16'($urandom_range(0, 19)) : 16'($urandom);
  endtask

  task automatic start_row(input int row);
    @(negedge clk);
    push_exp(row);
    row_select = 4'(row);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 1000) begin
      @(negedge clk);
      k++;
      if (busy) begin
        for (int i = 0; i < 2; i++) begin
          if (int'(bus.weight_addr[i*13 +: 13]) < wmin) wmin = int'(bus.weight_addr[i*13 +: 13]);
          if (int'(bus.weight_addr[i*13 +: 13]) > wmax) wmax = int'(bus.weight_addr[i*13 +: 13]);
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no done required=done", name);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_row_err"}, longint'(row_err), 0);
    chk({tag, "_overflow"}, longint'(overflow), 0);
    chk({tag, "_result"}, longint'(result), 0);
    chk({tag, "_paddr0"}, longint'(bus.pixel_addr[9:0]), 0);
    chk({tag, "_waddr0"}, longint'(bus.weight_addr[12:0]), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    start = 1'b0; abort = 1'b0; row_select = '0;
    s_start = 1'b0; s_abort = 1'b0; s_row = '0;
    for (int k = 0; k < 1024; k++) sm_pix[k] = (k < 10) ? 8'(k + 1) : 8'd0;
    for (int k = 0; k < 8192; k++) sm_wgt[k] = 16'd1;
    fill(0);
    repeat (3) @(negedge clk);
    chk_reset("rst");
    chk("sm_rst_busy", longint'(s_busy), 0);
    n_rst = 1'b1;
    @(negedge clk);
    chk_reset("idle");

    // Row 3, unit pixels and weights of two.
    fill(2);
    wmin = 32'h7fffffff; wmax = 0;
    start_row(3);
    wait_done("tp1");
    chk("tp1_result", longint'(result), 1568);
    chk("tp1_overflow", longint'(overflow), 0);
    chk("tp1_wmin", wmin, 2352);
    chk("tp1_wmax", wmax, 3135);

    // Full-scale operands force overflow.
    fill(3);
    start_row(4);
    wait_done("tp3");
`ifdef MAC_ROW_SATURATE_EN
    chk("tp3_result", longint'(result), 65535);
`else
    chk("tp3_result", longint'(result), 58128);
`endif
    chk("tp3_overflow", longint'(overflow), 1);

    repeat (6) begin
      fill(int'($urandom_range(0, 1)));
      start_row(int'($urandom_range(0, 9)));
      wait_done("rand");
    end

    // Out-of-range row request.
    prev_res = result; prev_ovf = overflow;
    @(negedge clk);
    row_select = 4'($urandom_range(10, 15));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rowerr_pulse", longint'(row_err), 1);
    chk("rowerr_busy", longint'(busy), 0);
    @(negedge clk);
    chk("rowerr_clear", longint'(row_err), 0);
    chk("rowerr_busy2", longint'(busy), 0);
    repeat (5) @(negedge clk);
    chk("rowerr_result", longint'(result), longint'(prev_res));
    chk("rowerr_overflow", longint'(overflow), longint'(prev_ovf));

    // Abort part-way through a row, then run a fresh row.
    fill(1);
    start_row(5);
    repeat (99) @(negedge clk);
    abort = 1'b1;
    void'(sbq.pop_back());
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_result", longint'(result), longint'(prev_res));
    chk("abort_overflow", longint'(overflow), longint'(prev_ovf));
    start_row(0);
    wait_done("after_abort");

    // Start held high across DONE: one new row begins only once back in IDLE.
    fill(0);
    @(negedge clk);
    push_exp(7);
    row_select = 4'd7;
    start = 1'b1;
    wait_done("held1");
    chk("held_idle_gap", longint'(busy), 0);
    push_exp(7);
    @(negedge clk);
    start = 1'b0;
    chk("held_restart", longint'(busy), 1);
    wait_done("held2");

    // Asynchronous reset in the middle of a row.
    fill(1);
    start_row(2);
    repeat (50) @(negedge clk);
    void'(sbq.pop_back());
    #2 n_rst = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk_reset("postrst");
    start_row(9);
    wait_done("recover");

    // Four lanes, ten elements: last beat has two masked lanes.
    @(negedge clk);
    ss = cyc + 1;
    s_row = 4'd1;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("sm_paddr0", longint'(sbus.pixel_addr[9:0]), 8);
    chk("sm_paddr1", longint'(sbus.pixel_addr[19:10]), 9);
    chk("sm_paddr2", longint'(sbus.pixel_addr[29:20]), 8);
    chk("sm_paddr3", longint'(sbus.pixel_addr[39:30]), 8);
    chk("sm_waddr3", longint'(sbus.weight_addr[51:39]), 18);
    n = 0;
    while (!s_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sm_latency", longint'(cyc - ss), 4);
    chk("sm_result", longint'(s_result), 55);
    chk("sm_overflow", longint'(s_overflow), 0);
    chk("sm_row_err", longint'(s_row_err), 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", longint'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
